// File: rtl/adder_4bit.sv
`default_nettype none
// ============================================================================
// Module   : adder_4bit
// Purpose  : Registered unsigned adder. Sums two WIDTH-bit operands into a
//            (WIDTH+1)-bit result whose MSB is the carry out. One-cycle
//            latency, one operation per cycle, no backpressure.
//            Optional build macro ADDER_SUB_EN adds a sub_i port that selects
//            subtraction (modulo 2**(WIDTH+1), MSB acts as borrow/sign).
// Ports    : clk_i     in   1        rising-edge clock
//            reset_i   in   1        asynchronous active-low reset
//            number_1  in   WIDTH    operand A (unsigned)
//            number_2  in   WIDTH    operand B (unsigned)
//            sub_i     in   1        subtract select (ADDER_SUB_EN only)
//            valid_i   in   1        operands valid this cycle
//            result    out  WIDTH+1  registered sum / difference
//            valid_o   out  1        result updated on the previous edge
// Revision : 1.0 - initial release
// ============================================================================
module adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] number_1,
  input  logic [WIDTH-1:0] number_2,
`ifdef ADDER_SUB_EN
  input  logic             sub_i,
`endif
  input  logic             valid_i,
  output logic [WIDTH:0]   result,
  output logic             valid_o
);

  logic [WIDTH:0] w_op_a;
  logic [WIDTH:0] w_op_b;
  logic [WIDTH:0] w_next_result;
  logic [WIDTH:0] r_result;
  logic           r_valid;

  // Zero-extend before the arithmetic so the carry (or borrow) lands in bit
  // WIDTH; the WIDTH+1-bit sum can never overflow.
  assign w_op_a = {1'b0, number_1};
  assign w_op_b = {1'b0, number_2};

`ifdef ADDER_SUB_EN
  // Difference wraps modulo 2**(WIDTH+1), so a negative result shows up as
  // its two's-complement pattern with bit WIDTH set.
  assign w_next_result = sub_i ? (w_op_a - w_op_b) : (w_op_a + w_op_b);
`else
  assign w_next_result = w_op_a + w_op_b;
`endif

  // Result holds across idle cycles; valid_o is a pure one-cycle strobe.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_result <= w_next_result;
      end
    end
  end

  assign result  = r_result;
  assign valid_o = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_adder_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_4bit
// Purpose  : Self-checking bench for adder_4bit. Table-driven single-shot
//            vectors plus hand-written sequences for asynchronous reset,
//            back-to-back throughput, hold-on-idle and reset abort.
//            Subtract vectors are compiled in with ADDER_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_4bit;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] num_a;
  logic [WIDTH-1:0] num_b;
  logic             valid_in;
  logic [WIDTH:0]   result;
  logic             valid_out;
`ifdef ADDER_SUB_EN
  logic             sub;
`endif

  int tests_run;
  int tests_failed;

  adder_4bit #(.WIDTH(WIDTH)) dut (
    .clk_i    (clk),
    .reset_i  (reset_n),
    .number_1 (num_a),
    .number_2 (num_b),
`ifdef ADDER_SUB_EN
    .sub_i    (sub),
`endif
    .valid_i  (valid_in),
    .result   (result),
    .valid_o  (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [WIDTH:0] act,
                       input logic [WIDTH:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  // Wait for the next rising edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{a: 4'd3,  b: 4'd4,  exp: 5'd7};
    vecs[1] = '{a: 4'd15, b: 4'd15, exp: 5'd30};
    vecs[2] = '{a: 4'd8,  b: 4'd8,  exp: 5'd16};
    vecs[3] = '{a: 4'd0,  b: 4'd0,  exp: 5'd0};
    vecs[4] = '{a: 4'd7,  b: 4'd9,  exp: 5'd16};
    vecs[5] = '{a: 4'd10, b: 4'd5,  exp: 5'd15};
    vecs[6] = '{a: 4'd15, b: 4'd0,  exp: 5'd15};
    vecs[7] = '{a: 4'd12, b: 4'd6,  exp: 5'd18};

    num_a    = '0;
    num_b    = '0;
    valid_in = 1'b0;
`ifdef ADDER_SUB_EN
    sub      = 1'b0;
`endif
    reset_n  = 1'b0;

    // Reset state, even with valid_i high across an edge.
    valid_in = 1'b1;
    num_a    = 4'd5;
    num_b    = 4'd5;
    tick();
    check("reset_result", result, 5'd0);
    check("reset_valid", {4'd0, valid_out}, 5'd1 - 5'd1);
    valid_in = 1'b0;
    #2 reset_n = 1'b1;

    // Table-driven single-shot vectors.
    for (int i = 0; i < 8; i++) begin
      num_a    = vecs[i].a;
      num_b    = vecs[i].b;
      valid_in = 1'b1;
      tick();
      check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), {4'd0, valid_out}, 5'd1);
      valid_in = 1'b0;
      tick();
      check($sformatf("vec%0d_hold", i), result, vecs[i].exp);
      check($sformatf("vec%0d_idle_valid", i), {4'd0, valid_out}, 5'd0);
    end

    // Asynchronous reset mid-cycle with a nonzero result.
    num_a    = 4'd3;
    num_b    = 4'd4;
    valid_in = 1'b1;
    tick();
    check("pre_async_result", result, 5'd7);
    valid_in = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_result", result, 5'd0);
    check("async_reset_valid", {4'd0, valid_out}, 5'd0);
    #1 reset_n = 1'b1;

    // Back-to-back operations, then idle.
    num_a = 4'd1; num_b = 4'd2; valid_in = 1'b1;
    tick();
    check("b2b0_result", result, 5'd3);
    check("b2b0_valid", {4'd0, valid_out}, 5'd1);
    num_a = 4'd9; num_b = 4'd9;
    tick();
    check("b2b1_result", result, 5'd18);
    check("b2b1_valid", {4'd0, valid_out}, 5'd1);
    num_a = 4'd15; num_b = 4'd1;
    tick();
    check("b2b2_result", result, 5'd16);
    check("b2b2_valid", {4'd0, valid_out}, 5'd1);
    valid_in = 1'b0;
    num_a = 4'd2; num_b = 4'd2;
    tick();
    check("b2b_idle_result", result, 5'd16);
    check("b2b_idle_valid", {4'd0, valid_out}, 5'd0);

    // Reset the cycle after 7+7 is accepted; nothing survives release.
    num_a = 4'd7; num_b = 4'd7; valid_in = 1'b1;
    tick();
    check("abort_pre_result", result, 5'd14);
    valid_in = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("abort_result", result, 5'd0);
    check("abort_valid", {4'd0, valid_out}, 5'd0);
    tick();
    #2 reset_n = 1'b1;
    tick();
    check("abort_release_result", result, 5'd0);
    check("abort_release_valid", {4'd0, valid_out}, 5'd0);
    tick();
    check("abort_release_result2", result, 5'd0);

`ifdef ADDER_SUB_EN
    sub = 1'b1; num_a = 4'd9; num_b = 4'd4; valid_in = 1'b1;
    tick();
    check("sub_9_4", result, 5'd5);
    num_a = 4'd3; num_b = 4'd5;
    tick();
    check("sub_3_5", result, 5'b11110);
    sub = 1'b0;
    tick();
    check("add_3_5", result, 5'd8);
    valid_in = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
